// File: rtl/opsel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : opsel_pkg
// Description : Shared definitions for the operand selector: operation codes,
//               error codes, FSM state encoding and small decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package opsel_pkg;

    // Operation codes carried on op_sel
    localparam logic [2:0] OP_TRANSPOSE = 3'd0;
    localparam logic [2:0] OP_ADD       = 3'd1;
    localparam logic [2:0] OP_SCALE     = 3'd2;
    localparam logic [2:0] OP_MATMUL    = 3'd3;
    localparam logic [2:0] OP_DET       = 3'd4;

    // Failure reasons reported on select_err_code
    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_ID    = 2'b01;  // ID out of range or slot empty
    localparam logic [1:0] ERR_DIM   = 2'b10;  // dimension mismatch
    localparam logic [1:0] ERR_FATAL = 2'b11;  // bad op, no matrices, tries exhausted

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_WAIT_A    = 4'd1,
        ST_FETCH_A   = 4'd2,
        ST_WAIT_B    = 4'd3,
        ST_FETCH_B   = 4'd4,
        ST_RAND_PICK = 4'd5,
        ST_CHECK     = 4'd6,
        ST_DONE      = 4'd7,
        ST_ERR       = 4'd8
    } state_t;

    // Unary operations use A as both operands and never fetch B
    function automatic logic is_unary(input logic [2:0] op);
        return (op == OP_TRANSPOSE) || (op == OP_SCALE) || (op == OP_DET);
    endfunction

    function automatic logic op_valid(input logic [2:0] op);
        return (op <= OP_DET);
    endfunction

    // Dimension compatibility of the fetched operands for a given operation
    function automatic logic dims_ok(input logic [2:0] op,
                                     input logic [2:0] a_rows,
                                     input logic [2:0] a_cols,
                                     input logic [2:0] b_rows,
                                     input logic [2:0] b_cols);
        logic ok;
        ok = 1'b1;
        case (op)
            OP_ADD:    ok = (a_rows == b_rows) && (a_cols == b_cols);
            OP_MATMUL: ok = (a_cols == b_rows);
            OP_DET:    ok = (a_rows == a_cols);
            default:   ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr8.sv
`default_nettype none
// ============================================================================
// Module      : lfsr8
// Description : Free-running 8-bit Fibonacci LFSR, polynomial
//               x^8 + x^6 + x^5 + x^4 + 1. Reloads SEED if it ever reaches 0.
// Ports       : clk, rst_n (async, active-low), q[7:0] current state
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] q
);

    logic [7:0] r_lfsr;
    logic       w_feedback;

    // Taps 8,6,5,4 map to bits 7,5,4,3
    assign w_feedback = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= SEED;
        end else if (r_lfsr == 8'h00) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_feedback};
        end
    end

    assign q = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/operand_selector.sv
`default_nettype none
// ============================================================================
// Module      : operand_selector
// Description : Picks operand matrix IDs (manually from the command parser or
//               at random) for the requested operation, fetches their
//               dimensions from the matrix store and checks compatibility.
// Ports       : start_select/manual_mode/op_sel/mat_count  - request
//               id_in/id_valid                             - manual IDs
//               dim_rd_en/dim_rd_id -> dim_rows/cols/exists - 1-cycle query
//               select_done/select_error/select_err_code   - status
//               selected_a/selected_b, busy
// Config      : OPSEL_RANDOM_EN defined -> random mode, LFSR and attempt
//               counter present; undefined -> manual path only.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_selector
    import opsel_pkg::*;
#(
    parameter int MAX_MATS   = 10,
    parameter int RAND_TRIES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_select,
    input  logic       manual_mode,
    input  logic [2:0] op_sel,
    input  logic [3:0] mat_count,
    input  logic [3:0] id_in,
    input  logic       id_valid,
    output logic       dim_rd_en,
    output logic [3:0] dim_rd_id,
    input  logic [2:0] dim_rows,
    input  logic [2:0] dim_cols,
    input  logic       dim_exists,
    output logic       select_done,
    output logic       select_error,
    output logic [1:0] select_err_code,
    output logic [3:0] selected_a,
    output logic [3:0] selected_b,
    output logic       busy
);

    localparam logic [4:0] c_max_mats = 5'(MAX_MATS);

    state_t     r_state;
    logic [2:0] r_op;
    logic       r_manual;
    logic       r_phase;       // 0: query on the bus, 1: result valid
    logic [3:0] r_id_a;
    logic [3:0] r_id_b;
    logic [2:0] r_a_rows;
    logic [2:0] r_a_cols;
    logic [2:0] r_b_rows;
    logic [2:0] r_b_cols;
    logic       r_dim_rd_en;
    logic [3:0] r_dim_rd_id;
    logic       r_select_done;
    logic       r_select_error;
    logic [1:0] r_err_code;
    logic [3:0] r_sel_a;
    logic [3:0] r_sel_b;

    logic       w_manual_in;
    logic [4:0] w_id_limit;
    logic       w_id_ok;
    logic       w_dims_ok;

    // Effective slot count is bounded by both the store occupancy and MAX_MATS
    assign w_id_limit = ({1'b0, mat_count} < c_max_mats) ? {1'b0, mat_count} : c_max_mats;
    assign w_id_ok    = ({1'b0, id_in} < w_id_limit);
    assign w_dims_ok  = dims_ok(r_op, r_a_rows, r_a_cols, r_b_rows, r_b_cols);

`ifdef OPSEL_RANDOM_EN
    localparam int c_tries_w = $clog2(RAND_TRIES + 3);

    logic [7:0]           w_lfsr;
    logic [3:0]           w_cand;
    logic                 w_cand_ok;
    logic                 r_pick_b;
    logic [c_tries_w-1:0] r_tries;
    logic [c_tries_w-1:0] w_tries_inc;
    logic                 w_tries_done;

    lfsr8 #(
        .SEED (8'hA5)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (w_lfsr)
    );

    assign w_manual_in  = manual_mode;
    assign w_cand       = w_lfsr[3:0];
    assign w_cand_ok    = ({1'b0, w_cand} < w_id_limit);
    assign w_tries_inc  = r_tries + c_tries_w'(1);
    // Evaluated only on a failure; successful fetches also consume attempts
    assign w_tries_done = (int'(w_tries_inc) >= RAND_TRIES);
`else
    assign w_manual_in  = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_op           <= OP_TRANSPOSE;
            r_manual       <= 1'b1;
            r_phase        <= 1'b0;
            r_id_a         <= 4'd0;
            r_id_b         <= 4'd0;
            r_a_rows       <= 3'd0;
            r_a_cols       <= 3'd0;
            r_b_rows       <= 3'd0;
            r_b_cols       <= 3'd0;
            r_dim_rd_en    <= 1'b0;
            r_dim_rd_id    <= 4'd0;
            r_select_done  <= 1'b0;
            r_select_error <= 1'b0;
            r_err_code     <= ERR_NONE;
            r_sel_a        <= 4'd0;
            r_sel_b        <= 4'd0;
`ifdef OPSEL_RANDOM_EN
            r_pick_b       <= 1'b0;
            r_tries        <= '0;
`endif
        end else begin
            r_select_error <= 1'b0;
            r_dim_rd_en    <= 1'b0;

            if (start_select) begin
                // Restart wins over everything, including an in-flight query
                r_select_done <= 1'b0;
                r_err_code    <= ERR_NONE;
                r_op          <= op_sel;
                r_manual      <= w_manual_in;
                r_phase       <= 1'b0;
`ifdef OPSEL_RANDOM_EN
                r_pick_b      <= 1'b0;
                r_tries       <= '0;
`endif
                if ((mat_count == 4'd0) || !op_valid(op_sel)) begin
                    r_state        <= ST_ERR;
                    r_err_code     <= ERR_FATAL;
                    r_select_error <= 1'b1;
                end else if (w_manual_in) begin
                    r_state <= ST_WAIT_A;
                end else begin
`ifdef OPSEL_RANDOM_EN
                    r_state <= ST_RAND_PICK;
`else
                    r_state <= ST_WAIT_A;
`endif
                end
            end else begin
                case (r_state)
                    ST_WAIT_A, ST_WAIT_B: begin
                        if (id_valid) begin
                            if (!w_id_ok) begin
                                r_state        <= ST_ERR;
                                r_err_code     <= ERR_ID;
                                r_select_error <= 1'b1;
                            end else begin
                                r_dim_rd_en <= 1'b1;
                                r_dim_rd_id <= id_in;
                                r_phase     <= 1'b0;
                                if (r_state == ST_WAIT_A) begin
                                    r_id_a  <= id_in;
                                    r_state <= ST_FETCH_A;
                                end else begin
                                    r_id_b  <= id_in;
                                    r_state <= ST_FETCH_B;
                                end
                            end
                        end
                    end

                    ST_FETCH_A, ST_FETCH_B: begin
                        if (!r_phase) begin
                            r_phase <= 1'b1;
                        end else begin
                            r_phase <= 1'b0;
                            if (!dim_exists) begin
                                if (r_manual) begin
                                    r_state        <= ST_ERR;
                                    r_err_code     <= ERR_ID;
                                    r_select_error <= 1'b1;
                                end
`ifdef OPSEL_RANDOM_EN
                                else if (w_tries_done) begin
                                    r_state        <= ST_ERR;
                                    r_err_code     <= ERR_FATAL;
                                    r_select_error <= 1'b1;
                                end else begin
                                    // Redraw the same operand
                                    r_tries <= w_tries_inc;
                                    r_state <= ST_RAND_PICK;
                                end
`endif
                            end else begin
`ifdef OPSEL_RANDOM_EN
                                if (!r_manual) begin
                                    r_tries <= w_tries_inc;
                                end
`endif
                                if (r_state == ST_FETCH_A) begin
                                    r_a_rows <= dim_rows;
                                    r_a_cols <= dim_cols;
                                    if (is_unary(r_op)) begin
                                        r_state <= ST_CHECK;
                                    end else if (r_manual) begin
                                        r_state <= ST_WAIT_B;
                                    end
`ifdef OPSEL_RANDOM_EN
                                    else begin
                                        r_pick_b <= 1'b1;
                                        r_state  <= ST_RAND_PICK;
                                    end
`endif
                                end else begin
                                    r_b_rows <= dim_rows;
                                    r_b_cols <= dim_cols;
                                    r_state  <= ST_CHECK;
                                end
                            end
                        end
                    end

`ifdef OPSEL_RANDOM_EN
                    ST_RAND_PICK: begin
                        // Out-of-range candidates are skipped without a query
                        if (w_cand_ok) begin
                            r_dim_rd_en <= 1'b1;
                            r_dim_rd_id <= w_cand;
                            r_phase     <= 1'b0;
                            if (r_pick_b) begin
                                r_id_b  <= w_cand;
                                r_state <= ST_FETCH_B;
                            end else begin
                                r_id_a  <= w_cand;
                                r_state <= ST_FETCH_A;
                            end
                        end
                    end
`endif

                    ST_CHECK: begin
                        if (w_dims_ok) begin
                            r_state       <= ST_DONE;
                            r_select_done <= 1'b1;
                            r_sel_a       <= r_id_a;
                            r_sel_b       <= is_unary(r_op) ? r_id_a : r_id_b;
                        end else if (r_manual) begin
                            r_state        <= ST_ERR;
                            r_err_code     <= ERR_DIM;
                            r_select_error <= 1'b1;
                        end
`ifdef OPSEL_RANDOM_EN
                        else if (w_tries_done) begin
                            r_state        <= ST_ERR;
                            r_err_code     <= ERR_FATAL;
                            r_select_error <= 1'b1;
                        end else begin
                            // Both operands are redrawn after a failed check
                            r_tries  <= w_tries_inc;
                            r_pick_b <= 1'b0;
                            r_state  <= ST_RAND_PICK;
                        end
`endif
                    end

                    ST_DONE: r_state <= ST_DONE;
                    ST_ERR:  r_state <= ST_IDLE;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign dim_rd_en       = r_dim_rd_en;
    assign dim_rd_id       = r_dim_rd_id;
    assign select_done     = r_select_done;
    assign select_error    = r_select_error;
    assign select_err_code = r_err_code;
    assign selected_a      = r_sel_a;
    assign selected_b      = r_sel_b;
    assign busy            = (r_state != ST_IDLE) && (r_state != ST_DONE) && (r_state != ST_ERR);

endmodule
`default_nettype wire

// File: tb/tb_operand_selector.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_selector
// Description : Directed self-checking bench for operand_selector with a
//               one-cycle-latency matrix store model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_selector;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_select;
    logic       manual_mode;
    logic [2:0] op_sel;
    logic [3:0] mat_count;
    logic [3:0] id_in;
    logic       id_valid;
    logic       dim_rd_en;
    logic [3:0] dim_rd_id;
    logic [2:0] dim_rows;
    logic [2:0] dim_cols;
    logic       dim_exists;
    logic       select_done;
    logic       select_error;
    logic [1:0] select_err_code;
    logic [3:0] selected_a;
    logic [3:0] selected_b;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;
    int n_rd     = 0;
    int rd_before;
    logic seen;

    logic [2:0] mem_rows   [16];
    logic [2:0] mem_cols   [16];
    logic       mem_exists [16];

    always #5 clk = ~clk;

    operand_selector #(
        .MAX_MATS   (10),
        .RAND_TRIES (16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_select    (start_select),
        .manual_mode     (manual_mode),
        .op_sel          (op_sel),
        .mat_count       (mat_count),
        .id_in           (id_in),
        .id_valid        (id_valid),
        .dim_rd_en       (dim_rd_en),
        .dim_rd_id       (dim_rd_id),
        .dim_rows        (dim_rows),
        .dim_cols        (dim_cols),
        .dim_exists      (dim_exists),
        .select_done     (select_done),
        .select_error    (select_error),
        .select_err_code (select_err_code),
        .selected_a      (selected_a),
        .selected_b      (selected_b),
        .busy            (busy)
    );

    // Matrix store: answers one cycle after the query strobe
    always @(posedge clk) begin
        if (dim_rd_en) begin
            dim_rows   <= mem_rows[dim_rd_id];
            dim_cols   <= mem_cols[dim_rd_id];
            dim_exists <= mem_exists[dim_rd_id];
            n_rd       <= n_rd + 1;
        end
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [2:0] op, input logic man, input logic [3:0] cnt);
        op_sel       = op;
        manual_mode  = man;
        mat_count    = cnt;
        start_select = 1'b1;
        tick();
        start_select = 1'b0;
    endtask

    task automatic do_strobe(input logic [3:0] id);
        id_in    = id;
        id_valid = 1'b1;
        tick();
        id_valid = 1'b0;
    endtask

    // Waits (bounded) for select_done or select_error
    task automatic wait_result(input int bound, output logic found);
        found = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (select_done || select_error) begin
                found = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic set_slot(input int idx, input logic [2:0] r, input logic [2:0] c, input logic e);
        mem_rows[idx]   = r;
        mem_cols[idx]   = c;
        mem_exists[idx] = e;
    endtask

    initial begin
        rst_n        = 1'b0;
        start_select = 1'b0;
        manual_mode  = 1'b1;
        op_sel       = 3'd0;
        mat_count    = 4'd0;
        id_in        = 4'd0;
        id_valid     = 1'b0;
        for (int i = 0; i < 16; i++) set_slot(i, 3'd0, 3'd0, 1'b0);
        set_slot(0, 3'd2, 3'd3, 1'b1);
        set_slot(1, 3'd2, 3'd2, 1'b1);
        set_slot(2, 3'd2, 3'd3, 1'b1);
        set_slot(3, 3'd3, 3'd3, 1'b1);
        tick();
        tick();

        // Reset state
        check_value("rst_done",   select_done,     0);
        check_value("rst_error",  select_error,    0);
        check_value("rst_code",   select_err_code, 0);
        check_value("rst_sel_a",  selected_a,      0);
        check_value("rst_sel_b",  selected_b,      0);
        check_value("rst_busy",   busy,            0);
        check_value("rst_rd_en",  dim_rd_en,       0);
        rst_n = 1'b1;
        tick();

        // Manual add: IDs 0 (2x3) and 2 (2x3); done exactly 3 edges after B strobe
        rd_before = n_rd;
        do_start(3'd1, 1'b1, 4'd3);
        check_value("add_busy", busy, 1);
        do_strobe(4'd0);
        tick();
        tick();
        do_strobe(4'd2);
        tick();
        tick();
        check_value("add_done_early", select_done, 0);
        tick();
        check_value("add_done",   select_done,     1);
        check_value("add_sel_a",  selected_a,      0);
        check_value("add_sel_b",  selected_b,      2);
        check_value("add_error",  select_error,    0);
        check_value("add_code",   select_err_code, 0);
        check_value("add_busy_end", busy,          0);
        check_value("add_reads",  n_rd - rd_before, 2);

        // Manual multiply 2x3 * 2x2 -> dimension mismatch; restart clears done
        do_start(3'd3, 1'b1, 4'd3);
        check_value("mul_done_clr", select_done, 0);
        do_strobe(4'd0);
        tick();
        tick();
        do_strobe(4'd1);
        wait_result(10, seen);
        check_value("mul_error", select_error,    1);
        check_value("mul_code",  select_err_code, 2);
        check_value("mul_done",  select_done,     0);
        tick();
        check_value("mul_pulse", select_error,    0);
        check_value("mul_hold",  select_err_code, 2);

        // Manual transpose, ID 5 with 2 slots: immediate range error, no query
        rd_before = n_rd;
        do_start(3'd0, 1'b1, 4'd2);
        do_strobe(4'd5);
        check_value("rng_error", select_error,    1);
        check_value("rng_code",  select_err_code, 1);
        tick();
        check_value("rng_pulse", select_error,    0);
        check_value("rng_noread", n_rd - rd_before, 0);

        // No matrices -> code 11 one cycle after start
        do_start(3'd1, 1'b1, 4'd0);
        check_value("empty_error", select_error,    1);
        check_value("empty_code",  select_err_code, 3);
        tick();
        check_value("empty_pulse", select_error,    0);

        // Invalid op code 6
        do_start(3'd6, 1'b1, 4'd3);
        check_value("badop_error", select_error,    1);
        check_value("badop_code",  select_err_code, 3);

        // Empty slot 4 (in range with 5 slots) -> code 01 after the fetch
        do_start(3'd0, 1'b1, 4'd5);
        do_strobe(4'd4);
        wait_result(10, seen);
        check_value("hole_error", select_error,    1);
        check_value("hole_code",  select_err_code, 1);

        // Unary determinant on 2x2: done 3 edges after the A strobe, B = A
        do_start(3'd4, 1'b1, 4'd3);
        do_strobe(4'd1);
        tick();
        tick();
        check_value("det_done_early", select_done, 0);
        tick();
        check_value("det_done",  select_done, 1);
        check_value("det_sel_a", selected_a,  1);
        check_value("det_sel_b", selected_b,  1);

        // Determinant of a non-square matrix
        do_start(3'd4, 1'b1, 4'd3);
        do_strobe(4'd0);
        wait_result(10, seen);
        check_value("det_ns_error", select_error,    1);
        check_value("det_ns_code",  select_err_code, 2);

        // Restart while waiting for B: old A is dropped
        do_start(3'd1, 1'b1, 4'd3);
        do_strobe(4'd0);
        tick();
        tick();
        do_start(3'd1, 1'b1, 4'd3);
        do_strobe(4'd2);
        tick();
        tick();
        do_strobe(4'd0);
        wait_result(10, seen);
        check_value("rst_wb_done",  select_done, 1);
        check_value("rst_wb_sel_a", selected_a,  2);
        check_value("rst_wb_sel_b", selected_b,  0);

`ifdef OPSEL_RANDOM_EN
        // Random determinant, all four slots 3x3
        for (int i = 0; i < 4; i++) set_slot(i, 3'd3, 3'd3, 1'b1);
        do_start(3'd4, 1'b0, 4'd4);
        wait_result(600, seen);
        check_value("rnd_found", seen,        1);
        check_value("rnd_done",  select_done, 1);
        check_value("rnd_a_lt4", (selected_a < 4'd4), 1);
        check_value("rnd_b_eq_a", selected_b, selected_a);

        // Random with every slot empty -> tries exhausted
        for (int i = 0; i < 4; i++) set_slot(i, 3'd3, 3'd3, 1'b0);
        do_start(3'd4, 1'b0, 4'd4);
        wait_result(3000, seen);
        check_value("rnd_ex_error", select_error,    1);
        check_value("rnd_ex_code",  select_err_code, 3);
        for (int i = 0; i < 4; i++) set_slot(i, 3'd3, 3'd3, 1'b1);
`else
        // manual_mode is ignored: IDs still come from id_in
        do_start(3'd0, 1'b0, 4'd3);
        do_strobe(4'd2);
        wait_result(10, seen);
        check_value("nornd_done",  select_done, 1);
        check_value("nornd_sel_a", selected_a,  2);
`endif

        // Reset in the middle of a selection: back to idle, no error pulse
        do_start(3'd1, 1'b1, 4'd3);
        do_strobe(4'd0);
        rst_n = 1'b0;
        #1;
        check_value("mid_rst_busy",  busy,         0);
        check_value("mid_rst_error", select_error, 0);
        check_value("mid_rst_rd_en", dim_rd_en,    0);
        tick();
        rst_n = 1'b1;
        tick();
        check_value("mid_rst_idle",  busy,         0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/operand_selector.md
# operand_selector

Chooses the operand matrix IDs for a matrix operation and checks that their dimensions suit the selected operation. It sits directly downstream of the top-level control FSM. It consumes `start_select`, `manual_mode` and `op_sel`, and returns `select_done`, `select_error`, `selected_a` and `selected_b`. Operand dimensions are read from the matrix store over a one-cycle-latency query port. Manual IDs arrive as strobes from the UART command parser.

## Interface
- `MAX_MATS`, default 10: number of matrix slots; valid IDs are 0..`MAX_MATS`-1.
- `RAND_TRIES`, default 16: number of random draws allowed before an error is reported.
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `start_select`, in, 1: one-cycle pulse that starts (or restarts) a selection.
- `manual_mode`, in, 1: 1 = IDs come from `id_in`; 0 = IDs are drawn at random.
- `op_sel`, in, 3: operation code, sampled on `start_select`.
- `mat_count`, in, 4: number of populated slots.
- `id_in`, in, 4: manual ID.
- `id_valid`, in, 1: one-cycle strobe qualifying `id_in`.
- `dim_rd_en`, out, 1: dimension query strobe.
- `dim_rd_id`, out, 4: ID being queried.
- `dim_rows`, in, 3: row count of the queried ID, valid 1 cycle after `dim_rd_en`.
- `dim_cols`, in, 3: column count of the queried ID, valid 1 cycle after `dim_rd_en`.
- `dim_exists`, in, 1: 1 if the queried slot holds a matrix, valid 1 cycle after `dim_rd_en`.
- `select_done`, out, 1: level; high from a successful check until the next `start_select` or reset.
- `select_error`, out, 1: one-cycle pulse on failure.
- `select_err_code`, out, 2: failure reason, held until the next `start_select`. 01 = ID out of range or slot empty, 10 = dimension mismatch, 11 = bad op, no matrices, or random tries exhausted.
- `selected_a`, out, 4: chosen A operand.
- `selected_b`, out, 4: chosen B operand.
- `busy`, out, 1: high in every state except IDLE, DONE and ERR.

## Operation
- **Op codes:**
  - 0 transpose: unary.
  - 1 add: binary; requires equal rows and equal columns.
  - 2 scalar multiply: unary.
  - 3 matrix multiply: binary; requires A.cols == B.rows.
  - 4 determinant: unary; requires square A.
  - 5..7: rejected with code 11.
- **Unary ops:** B is forced equal to A, and B is neither fetched nor prompted for.
- **States:** IDLE, WAIT_A, FETCH_A, WAIT_B, FETCH_B, RAND_PICK, CHECK, DONE, ERR.
- **On `start_select`** (accepted in any state, including mid-selection):
  - Clear `select_done` and `select_err_code`.
  - Latch `op_sel` and `manual_mode`.
  - If `mat_count` == 0 or the op code is invalid, go to ERR with code 11.
  - Otherwise go to WAIT_A (manual) or RAND_PICK (random).
- **Manual path:**
  - WAIT_A: on `id_valid`, if `id_in` ≥ `mat_count`, go to ERR with code 01. Otherwise latch the ID and go to FETCH_A.
  - FETCH_A: issue the query, wait one cycle, sample the dimensions. If `dim_exists` = 0, go to ERR with code 01.
  - Then WAIT_B/FETCH_B the same way for binary ops, or go straight to CHECK for unary ops.
  - `id_valid` is ignored outside WAIT_A and WAIT_B.
- **Random path:**
  - The candidate is `lfsr[3:0]`. Reject it if it is ≥ `mat_count` or `dim_exists` = 0.
  - For binary ops, draw A first and then B. B may equal A.
  - Each fetch-and-check, including a failed CHECK, consumes one attempt. After a failed CHECK, both A and B are redrawn.
  - After `RAND_TRIES` attempts without success, go to ERR with code 11.
- **CHECK:**
  - Pass: go to DONE, drive `selected_a`/`selected_b`, and set `select_done`.
  - Fail in manual mode: go to ERR with code 10.
- **ERR:** pulse `select_error` for one cycle, then return to IDLE holding `select_err_code`.
- **DONE:** hold until the next `start_select`.

## Timing
- **Reset:**
  - All outputs are 0 and the state is IDLE.
  - The LFSR is set to 8'hA5.
  - `selected_a`/`selected_b` are 0.
- **Dimension query:** `dim_rd_en` is a single-cycle pulse per query. `dim_rows`, `dim_cols` and `dim_exists` are sampled exactly 1 cycle later.
- **Manual latency:** from `id_valid` to the next state is 1 cycle.
  - Unary op: `select_done` rises 3 cycles after the A strobe.
  - Binary op: `select_done` rises 3 cycles after the B strobe.
- **Error latency:** `select_error` is asserted on the cycle after the failing decision.
  - With `mat_count` == 0, `select_error` pulses 1 cycle after `start_select`.
- **LFSR:**
  - Polynomial x⁸+x⁶+x⁵+x⁴+1, shifts every cycle.
  - It never locks at 0: a 0 value forces a reload of 8'hA5.
- **Restart and simultaneous events:**
  - `start_select` wins over `id_valid` in the same cycle.
  - A query result that is still in flight when `start_select` arrives is discarded.
- **Reset mid-selection:** returns to IDLE immediately, with no `select_error` pulse.

## Configuration
- **`OPSEL_RANDOM_EN` defined:** random mode, LFSR and attempt counter are present.
- **`OPSEL_RANDOM_EN` undefined:**
  - `manual_mode` is ignored and the manual path is always used.
  - RAND_PICK and the LFSR are removed.
  - Code 11 no longer covers exhausted tries.

## Structure
- **Shared package `opsel_pkg`:** op-code constants (OP_TRANSPOSE … OP_DET), error-code constants, the state encoding, and an `is_unary` function.
- **Sub-module `lfsr8`:** free-running 8-bit LFSR with a seed parameter, instantiated only under `OPSEL_RANDOM_EN`.

## Test plan
- Manual add, `mat_count`=3: IDs 0 (2×3) and 2 (2×3) → `select_done`=1, A=0, B=2, no error.
- Manual multiply: IDs 0 (2×3) and 1 (2×2) → one-cycle `select_error` pulse, code 10, `select_done`=0.
- Manual transpose, `mat_count`=2, `id_in`=5 → `select_error` pulse, code 01, no `dim_rd_en` issued.
- `start_select` with `mat_count`=0, or with `op_sel`=6 → error code 11 one cycle later.
- Random determinant, `mat_count`=4, all slots 3×3 → `select_done` within `RAND_TRIES` attempts, A < 4, B = A.
- Second `start_select` during WAIT_B → `select_done` cleared, FSM back in WAIT_A, previous A discarded.
